nios_fprint_dct_capture_ctrl: RTL
=================================

NIOS_FPRINT_DCT_CAPTURE_CTRL -- requirements
Module: nios_fprint_dct_capture_ctrl

Interface
REQ-001 Parameter ATOM_W, default 3: width of one trace atom in bits.
REQ-002 Parameter NUM_ATOMS, default 10: atoms per packed word; ATOM_W*NUM_ATOMS SHALL equal 30.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port arm, input, 1: single-cycle pulse that arms capture from IDLE or DONE.
REQ-006 Port abort, input, 1: discard all data and return to IDLE.
REQ-007 Port trig_start, input, 1: begin capture; sampled only in ARMED.
REQ-008 Port trig_stop, input, 1: end capture; sampled only in CAPTURE.
REQ-009 Port atom_valid, input, 1, plus atom_data, input, ATOM_W: trace atom source with no backpressure.
REQ-010 Port out_valid, output, 1; out_data, output, 30; out_count, output, 4; out_ready, input, 1: packed-word valid/ready output.
REQ-011 Port dct_buffer, output, 30, and dct_count, output, 4: live packing buffer and number of atoms it holds.
REQ-012 Port test_ending, output, 1: high while in FLUSH.
REQ-013 Port test_has_ended, output, 1: high while in DONE.
REQ-014 Port overflow, output, 1: sticky flag indicating at least one atom was dropped.

Function
REQ-015 The FSM SHALL have the states IDLE, ARMED, CAPTURE, FLUSH and DONE.
REQ-016 Transitions: IDLE+arm -> ARMED; ARMED+trig_start -> CAPTURE; CAPTURE+trig_stop -> FLUSH; FLUSH -> DONE once dct_count==0 and out_valid==0; DONE+arm -> ARMED.
REQ-017 abort SHALL take precedence over every other input: the next state is IDLE, with out_valid, dct_count, dct_buffer and overflow all cleared.
REQ-018 Atoms SHALL be accepted only in CAPTURE, including the trig_stop cycle but excluding the trig_start cycle.
REQ-019 An accepted atom SHALL be written to dct_buffer[dct_count*ATOM_W +: ATOM_W], and dct_count SHALL increment by 1.
REQ-020 Buffer slots at or above dct_count SHALL read as zero.
REQ-021 Output register transfer: when dct_count==NUM_ATOMS and (out_valid==0 or out_ready==1), the buffer SHALL move to out_data with out_count=NUM_ATOMS and out_valid=1, and the buffer SHALL clear in the same cycle.
REQ-022 An atom arriving in the transfer cycle SHALL land in slot 0, giving dct_count=1.
REQ-023 When the buffer is full and no transfer is possible, an arriving atom SHALL be dropped and overflow SHALL be set; the buffer contents SHALL be unchanged.
REQ-024 In FLUSH with 0<dct_count<NUM_ATOMS, a partial word SHALL transfer under the same output-free rule, with out_count=dct_count and unused upper bits zero.
REQ-025 out_valid SHALL fall on the cycle after out_ready is high, unless a new word loads in that same cycle.
REQ-026 While out_valid=1 and out_ready=0, out_data and out_count SHALL hold stable.
REQ-027 Latency: the tenth atom accepted in cycle N with the output free SHALL produce out_valid=1 at cycle N+1.
REQ-028 The arm pulse in DONE SHALL clear overflow; arm in any state other than IDLE or DONE SHALL be ignored.
REQ-029 trig_start outside ARMED and trig_stop outside CAPTURE SHALL be ignored.

Reset
REQ-030 While reset is high, the next state SHALL be IDLE and all outputs SHALL be 0: out_valid, out_data, out_count, dct_buffer, dct_count, test_ending, test_has_ended and overflow.
REQ-031 reset SHALL take precedence over abort.
REQ-032 reset asserted mid-capture SHALL discard the buffered data and the output register.

Verification
REQ-033 arm, trig_start, then 10 atoms with values 0..7,0,1 and out_ready=1 -> one word, out_data=30'o1076543210, out_count=10, out_valid high for exactly 1 cycle.
REQ-034 Capture 4 atoms of value 5, then trig_stop -> FLUSH, then partial word out_data=30'o5555, out_count=4, then DONE with test_has_ended=1.
REQ-035 out_ready=0 while 21 atoms arrive -> first word held stable, second word full in the buffer, 21st atom dropped, overflow=1; after out_ready=1 both words emerge in order.
REQ-036 Atom arrives in the transfer cycle -> dct_count=1 and dct_buffer[2:0] equal to that atom.
REQ-037 abort, or reset, asserted mid-CAPTURE with dct_count=6 and out_valid=1 -> next cycle IDLE with all outputs zero; a subsequent arm/trig_start capture behaves normally.

Source files
------------

// File: rtl/nios_fprint_dct_capture_ctrl_if.sv
// Trace-capture control/data bundle: arm/trigger controls, atom source,
// packed-word output and live status of the packing buffer.
interface nios_fprint_dct_capture_ctrl_if #(
    parameter int ATOM_W    = 3,
    parameter int NUM_ATOMS = 10
);
    logic              arm;
    logic              abort;
    logic              trig_start;
    logic              trig_stop;
    logic              atom_valid;
    logic [ATOM_W-1:0] atom_data;

    logic              out_valid;
    logic [29:0]       out_data;
    logic [3:0]        out_count;
    logic              out_ready;

    logic [29:0]       dct_buffer;
    logic [3:0]        dct_count;
    logic              test_ending;
    logic              test_has_ended;
    logic              overflow;

    modport slave (
        input  arm, abort, trig_start, trig_stop, atom_valid, atom_data, out_ready,
        output out_valid, out_data, out_count, dct_buffer, dct_count,
               test_ending, test_has_ended, overflow
    );

    modport master (
        output arm, abort, trig_start, trig_stop, atom_valid, atom_data, out_ready,
        input  out_valid, out_data, out_count, dct_buffer, dct_count,
               test_ending, test_has_ended, overflow
    );
endinterface

// File: rtl/nios_fprint_dct_capture_ctrl.sv
// Trace capture controller: packs ATOM_W-bit atoms into 30-bit words, hands
// them out over a valid/ready register and drops atoms when both stages are full.
module nios_fprint_dct_capture_ctrl #(
    parameter int ATOM_W    = 3,
    parameter int NUM_ATOMS = 10
) (
    input logic                          clk,
    input logic                          reset,
    nios_fprint_dct_capture_ctrl_if.slave bus
);
    localparam int         WORD_W   = ATOM_W * NUM_ATOMS;
    localparam logic [3:0] FULL_CNT = 4'(NUM_ATOMS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] buffer_q, buffer_d;
    logic [3:0]        count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [3:0]        out_count_q, out_count_d;
    logic              overflow_q, overflow_d;

    logic out_free;
    logic xfer;
    logic accept;

    always_comb begin
        state_d     = state_q;
        buffer_d    = buffer_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        overflow_d  = overflow_q;

        out_free = !out_valid_q || bus.out_ready;
        xfer     = out_free &&
                   ((count_q == FULL_CNT) || (state_q == S_FLUSH && count_q != '0));
        accept   = (state_q == S_CAPTURE) && bus.atom_valid;

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = buffer_q;
            out_count_d = count_q;
            buffer_d    = '0;
            count_d     = '0;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // Atom placement uses the post-transfer count so a same-cycle atom lands in slot 0.
        if (accept) begin
            if (count_d != FULL_CNT) begin
                for (int unsigned i = 0; i < NUM_ATOMS; i++) begin
                    if (i == 32'(count_d)) begin
                        buffer_d[i*ATOM_W +: ATOM_W] = bus.atom_data;
                    end
                end
                count_d = count_d + 4'd1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.arm) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (bus.trig_start) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (bus.trig_stop) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (count_q == '0 && !out_valid_q) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.arm) begin
                    state_d    = S_ARMED;
                    overflow_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.abort) begin
            state_d     = S_IDLE;
            buffer_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_count_d = '0;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            buffer_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            buffer_q    <= buffer_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = out_data_q;
    assign bus.out_count      = out_count_q;
    assign bus.dct_buffer     = buffer_q;
    assign bus.dct_count      = count_q;
    assign bus.overflow       = overflow_q;
    assign bus.test_ending    = (state_q == S_FLUSH);
    assign bus.test_has_ended = (state_q == S_DONE);
endmodule
